// File: rtl/periph_timer.sv
// periph_timer: memory-mapped timer / LED / seven-segment peripheral.
//
// Purpose: a reloading 32-bit timer (TH = reload, TL = counter, TCON =
// control/status), an LED register, a seven-segment register and a
// free-running cycle counter (systick), all on a simple CPU bus at
// base 0x4000_0000.
//
// Ports:
//   clk     in   1   system clock, rising edge
//   reset   in   1   asynchronous active-low reset
//   rd      in   1   CPU read strobe
//   wr      in   1   CPU write strobe
//   addr    in  32   CPU byte address (addr[1:0] ignored)
//   wdata   in  32   CPU write data
//   rdata   out 32   CPU read data, combinational
//   led     out  8   LED register
//   digi    out 12   seven-segment drive ([11:8] enables, [7:0] segments)
//   irqout  out  1   timer interrupt request (level)
module periph_timer (
   input  logic        clk,
   input  logic        reset,
   input  logic        rd,
   input  logic        wr,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic [7:0]  led,
   output logic [11:0] digi,
   output logic        irqout
);

   // Word indices (addr[7:2]) of the register map.
   localparam logic [5:0] W_TH   = 6'd0;
   localparam logic [5:0] W_TL   = 6'd1;
   localparam logic [5:0] W_TCON = 6'd2;
   localparam logic [5:0] W_LED  = 6'd3;
   localparam logic [5:0] W_SYST = 6'd4;
   localparam logic [5:0] W_DIGI = 6'd5;

   logic [31:0] th_q, th_d;
   logic [31:0] tl_q, tl_d;
   logic [2:0]  tcon_q, tcon_d;
   logic [7:0]  led_q, led_d;
   logic [11:0] digi_q, digi_d;
   logic [31:0] systick_q, systick_d;

   logic        sel;
   logic [5:0]  word;
   logic        wr_th, wr_tl, wr_tcon, wr_led, wr_digi;
   logic        ovf;
   logic        ovf_irq;
   logic        unused_addr_lsb;

   assign sel  = (addr[31:8] == 24'h400000);
   assign word = addr[7:2];
   assign unused_addr_lsb = ^addr[1:0];

   assign wr_th   = wr && sel && (word == W_TH);
   assign wr_tl   = wr && sel && (word == W_TL);
   assign wr_tcon = wr && sel && (word == W_TCON);
   assign wr_led  = wr && sel && (word == W_LED);
   assign wr_digi = wr && sel && (word == W_DIGI);

   // A CPU write to TL pre-empts the reload, so it also suppresses the
   // overflow event. The interrupt-enable used is the pre-write value.
   assign ovf     = tcon_q[0] && (tl_q == 32'hFFFF_FFFF) && !wr_tl;
   assign ovf_irq = ovf && tcon_q[1];

   always_comb begin
      th_d      = wr_th ? wdata : th_q;
      led_d     = wr_led ? wdata[7:0] : led_q;
      digi_d    = wr_digi ? wdata[11:0] : digi_q;
      systick_d = systick_q + 32'd1;

      if (wr_tl) begin
         tl_d = wdata;
      end else if (!tcon_q[0]) begin
         tl_d = tl_q;
      end else if (tl_q == 32'hFFFF_FFFF) begin
         tl_d = th_q;
      end else begin
         tl_d = tl_q + 32'd1;
      end

      // Status bit is sticky: an overflow in the same cycle as a TCON
      // write is OR-ed in so the interrupt cannot be lost.
      if (wr_tcon) begin
         tcon_d = {wdata[2] | ovf_irq, wdata[1:0]};
      end else begin
         tcon_d = {tcon_q[2] | ovf_irq, tcon_q[1:0]};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         th_q      <= '0;
         tl_q      <= '0;
         tcon_q    <= '0;
         led_q     <= '0;
         digi_q    <= '0;
         systick_q <= '0;
      end else begin
         th_q      <= th_d;
         tl_q      <= tl_d;
         tcon_q    <= tcon_d;
         led_q     <= led_d;
         digi_q    <= digi_d;
         systick_q <= systick_d;
      end
   end

   always_comb begin
      rdata = 32'h0;
      if (rd && sel) begin
         case (word)
            W_TH:    rdata = th_q;
            W_TL:    rdata = tl_q;
            W_TCON:  rdata = {29'h0, tcon_q};
            W_LED:   rdata = {24'h0, led_q};
            W_SYST:  rdata = systick_q;
            W_DIGI:  rdata = {20'h0, digi_q};
            default: rdata = 32'h0;
         endcase
      end
   end

   assign led    = led_q;
   assign digi   = digi_q;
   assign irqout = tcon_q[1] & tcon_q[2];

endmodule

// File: tb/tb_periph_timer.sv
// Testbench for periph_timer: directed scenarios with literal expectations
// plus randomized bus traffic, all checked against a behavioural model.
module tb_periph_timer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        rd = 1'b0;
   logic        wr = 1'b0;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic [31:0] rdata;
   logic [7:0]  led;
   logic [11:0] digi;
   logic        irqout;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   localparam logic [23:0] BASE = 24'h400000;

   periph_timer dut (
      .clk    (clk),
      .reset  (reset),
      .rd     (rd),
      .wr     (wr),
      .addr   (addr),
      .wdata  (wdata),
      .rdata  (rdata),
      .led    (led),
      .digi   (digi),
      .irqout (irqout)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [31:0] m_th = 0, m_tl = 0, m_st = 0;
   logic [2:0]  m_tcon = 0;
   logic [7:0]  m_led = 0;
   logic [11:0] m_digi = 0;

   logic [31:0] n_th, n_tl, m_rdata;
   logic [2:0]  n_tcon;
   logic [7:0]  n_led;
   logic [11:0] n_digi;
   logic        m_hit, m_irq_set;
   logic [5:0]  m_word;

   always_comb begin
      m_hit  = (addr[31:8] == BASE);
      m_word = addr[7:2];
      n_th   = m_th;
      n_led  = m_led;
      n_digi = m_digi;
      n_tl   = m_tl;
      m_irq_set = 1'b0;
      // counting rules: enabled TL counts up, reloading from TH after all-ones
      if (m_tcon[0]) begin
         if (m_tl == 32'hFFFF_FFFF) begin
            n_tl = m_th;
            m_irq_set = m_tcon[1];
         end else begin
            n_tl = m_tl + 1;
         end
      end
      n_tcon = m_tcon | {m_irq_set, 2'b00};
      if (wr && m_hit) begin
         case (m_word)
            6'd0: n_th = wdata;
            6'd1: begin n_tl = wdata; n_tcon = m_tcon; end
            6'd3: n_led = wdata[7:0];
            6'd5: n_digi = wdata[11:0];
            default: ;
         endcase
         if (m_word == 6'd2)
            n_tcon = {wdata[2] | m_irq_set, wdata[1:0]};
      end
      m_rdata = 32'h0;
      if (rd && m_hit) begin
         case (m_word)
            6'd0: m_rdata = m_th;
            6'd1: m_rdata = m_tl;
            6'd2: m_rdata = 32'(m_tcon);
            6'd3: m_rdata = 32'(m_led);
            6'd4: m_rdata = m_st;
            6'd5: m_rdata = 32'(m_digi);
            default: m_rdata = 32'h0;
         endcase
      end
   end

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_th <= 0; m_tl <= 0; m_tcon <= 0; m_led <= 0; m_digi <= 0; m_st <= 0;
         cyc <= 0;
      end else begin
         m_th <= n_th; m_tl <= n_tl; m_tcon <= n_tcon;
         m_led <= n_led; m_digi <= n_digi; m_st <= m_st + 1;
         cyc <= cyc + 1;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // single compare process: every negedge, all outputs vs model
   always @(negedge clk) begin
      if ($time > 8) begin
         chk("led", 32'(led), 32'(m_led));
         chk("digi", 32'(digi), 32'(m_digi));
         chk("irqout", 32'(irqout), 32'(m_tcon[1] & m_tcon[2]));
         chk("rdata", rdata, m_rdata);
      end
   end

   // ---------------- stimulus helpers (start/end at posedge+1) ----------------
   task automatic wreg(input logic [7:0] off, input logic [31:0] d);
      wr = 1; rd = 0; addr = {BASE, off}; wdata = d;
      @(posedge clk); #1;
      wr = 0;
   endtask

   task automatic rd_chk(input logic [7:0] off, input logic [31:0] exp, input string nm);
      rd = 1; wr = 0; addr = {BASE, off};
      #2;
      chk(nm, rdata, exp);
      @(posedge clk); #1;
      rd = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] off;
      int pick;

      rd = 1; addr = {BASE, 8'h04};
      #12;
      chk("rst_led", 32'(led), 32'h0);
      chk("rst_digi", 32'(digi), 32'h0);
      chk("rst_irq", 32'(irqout), 32'h0);
      chk("rst_tl", rdata, 32'h0);
      rd = 0;
      #10 reset = 1;               // release mid-cycle (t=22)
      @(posedge clk); #1;

      // overflow with interrupt
      wreg(8'h00, 32'hFFFF_FF00);
      wreg(8'h04, 32'hFFFF_FFFE);
      wreg(8'h08, 32'h3);
      rd_chk(8'h04, 32'hFFFF_FFFE, "tl_pre");
      rd_chk(8'h04, 32'hFFFF_FFFF, "tl_max");
      rd_chk(8'h04, 32'hFFFF_FF00, "tl_reload");
      chk("irq_set", 32'(irqout), 32'h1);
      rd_chk(8'h08, 32'h7, "tcon7");

      // clear status, disable interrupt
      wreg(8'h08, 32'h7 & 32'hFFF9);
      chk("irq_clr", 32'(irqout), 32'h0);
      rd_chk(8'h08, 32'h1, "tcon1");
      wreg(8'h04, 32'hFFFF_FFFE);
      idle(4);
      rd_chk(8'h08, 32'h1, "no_irq_ie0");
      chk("irq_ie0", 32'(irqout), 32'h0);

      // TL write beats overflow
      wreg(8'h08, 32'h3);
      wreg(8'h04, 32'hFFFF_FFFF);
      wreg(8'h04, 32'h5);
      rd_chk(8'h04, 32'h5, "tl_wr_prio");
      rd_chk(8'h08, 32'h3, "tcon_no_ovf");

      // TCON write coincident with overflow keeps the interrupt
      wreg(8'h04, 32'hFFFF_FFFF);
      wreg(8'h08, 32'h3);
      rd_chk(8'h08, 32'h7, "tcon_wr_ovf");
      chk("irq_wr_ovf", 32'(irqout), 32'h1);

      // LED / digits / systick / unmapped reads
      wreg(8'h0C, 32'h1AB);
      wreg(8'h14, 32'hF40);
      chk("led_ab", 32'(led), 32'hAB);
      chk("digi_f40", 32'(digi), 32'hF40);
      rd_chk(8'h0C, 32'h0000_00AB, "rd_led");
      rd_chk(8'h10, 32'(cyc), "rd_systick");
      rd_chk(8'h20, 32'h0, "rd_unmapped");
      rd = 0; addr = {BASE, 8'h0C}; #2;
      chk("rd_idle", rdata, 32'h0);
      @(posedge clk); #1;

      // asynchronous reset mid-count
      wreg(8'h08, 32'h3);
      idle(5);
      #2;
      rd = 1; addr = {BASE, 8'h04};
      reset = 0;
      #1;
      chk("arst_led", 32'(led), 32'h0);
      chk("arst_digi", 32'(digi), 32'h0);
      chk("arst_irq", 32'(irqout), 32'h0);
      chk("arst_tl", rdata, 32'h0);
      rd = 0;
      @(posedge clk); #2;
      reset = 1;
      @(posedge clk); #1;
      rd_chk(8'h04, 32'h0, "tl_hold0");
      rd_chk(8'h04, 32'h0, "tl_hold1");
      wreg(8'h08, 32'h1);
      idle(2);
      rd_chk(8'h04, 32'h2, "tl_resume");

      // randomized traffic, checked every cycle by the compare process
      for (int i = 0; i < 3000; i++) begin
         rd = 1'($urandom);
         wr = 1'($urandom_range(0, 2) == 0);
         pick = $urandom_range(0, 11);
         wdata = $urandom;
         if (pick <= 5) begin
            off = {pick[5:0], 2'(pick)};
            if (pick == 1 || pick == 0) wdata = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            if (pick == 2 && $urandom_range(0, 3) != 0) wdata[0] = 1'b1;
            addr = {BASE, off};
         end else if (pick <= 7) begin
            addr = {BASE, 6'($urandom_range(6, 63)), 2'($urandom)};
         end else if (pick <= 9) begin
            addr = $urandom;
            if (addr[31:8] == BASE) addr[31] = ~addr[31];
         end else begin
            wr = 0;
            addr = {BASE, 6'($urandom_range(0, 5)), 2'b00};
         end
         @(posedge clk); #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/periph_timer.md
PERIPH_TIMER -- requirements
Module: periph_timer

Interface
REQ-001 SHALL have one clock domain, with reset asynchronous and active-low.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous active-low reset.
REQ-004 rd  input  1  CPU read strobe.
REQ-005 wr  input  1  CPU write strobe, sampled on clk rising edge.
REQ-006 addr  input  32  CPU byte address.
REQ-007 wdata  input  32  CPU write data.
REQ-008 rdata  output  32  CPU read data, combinational.
REQ-009 led  output  8  LED register contents.
REQ-010 digi  output  12  seven-segment drive: [11:8] digit enables, [7:0] segment pattern.
REQ-011 irqout  output  1  timer interrupt request to the CPU, level.

Function
REQ-012 Block SHALL be selected only when addr[31:8] == 24'h400000; addr[1:0] are ignored.
REQ-013 Register map SHALL be: 0x00 TH rw32; 0x04 TL rw32; 0x08 TCON rw3; 0x0C led rw8; 0x10 systick ro32; 0x14 digi rw12.
REQ-014 TCON bits SHALL be: [0] timer enable; [1] interrupt enable; [2] interrupt status.
REQ-015 A write with wr=1 at a mapped rw offset SHALL update that register on the next rising edge with wdata truncated to the register width.
REQ-016 Writes to 0x10, to unmapped offsets, or outside the base SHALL be ignored.
REQ-017 rdata SHALL return the selected register zero-extended to 32 bits when rd=1 and the address is mapped.
REQ-018 rdata SHALL be 32'h0 when rd=0, when the address is unmapped, or when the address is outside the base.
REQ-019 When TCON[0]=1 and no TL write occurs, TL SHALL increment by 1 every cycle.
REQ-020 The cycle after TL==32'hFFFFFFFF, TL SHALL load TH (overflow); no intermediate wrap to 0 SHALL occur.
REQ-021 On overflow, when TCON[1]=1, TCON[2] SHALL be set to 1.
REQ-022 On overflow, when TCON[1]=0, TCON[2] SHALL be unchanged.
REQ-023 When TCON[0]=0, TL SHALL hold its value.
REQ-024 A CPU write to TL SHALL take priority over increment or reload in the same cycle.
REQ-025 A CPU write to TCON in the same cycle as an overflow SHALL set bits [1:0] from wdata.
REQ-026 In that same cycle, bit [2] SHALL become wdata[2] OR the overflow set, so an interrupt is never lost.
REQ-027 Overflow evaluation SHALL use the pre-write TCON[1].
REQ-028 irqout SHALL equal TCON[1] AND TCON[2], with no registered delay.
REQ-029 Software SHALL clear TCON[2] only by writing TCON.
REQ-030 systick SHALL be a free-running 32-bit counter incrementing every cycle regardless of TCON, wrapping from FFFFFFFF to 0.
REQ-031 led and digi SHALL drive their outputs directly from their registers.

Reset
REQ-032 While reset=0, TH, TL, TCON, led, digi and systick SHALL be 0 immediately, without waiting for a clock edge.
REQ-033 While reset=0, irqout SHALL be 0.
REQ-034 Assertion of reset mid-count SHALL abort counting.
REQ-035 After reset release, counting SHALL resume only after TCON[0] is rewritten.
REQ-036 The first rising edge after reset deasserts SHALL perform normal operation.

Verification
REQ-037 Reset, then write TH=FFFFFF00, TL=FFFFFFFE, TCON=3 -> TL=FFFFFFFF on the next cycle; TL=FFFFFF00 and TCON=7 one cycle later; irqout=1.
REQ-038 With irqout=1, read TCON (=7) and write TCON=7&FFF9=1 -> irqout=0 next cycle; TL keeps counting; no new interrupt while TCON[1]=0 despite later overflows.
REQ-039 TCON=3 with TL=FFFFFFFF, and a TL write of 5 in the same cycle -> TL=5 and TCON[2]=0.
REQ-040 TCON=3 with TL=FFFFFFFF, and a TCON write of 3 in the same cycle -> TCON=7.
REQ-041 Write 0x0C=0x1AB and 0x14=0xF40 -> led=AB, digi=F40; read 0x0C returns 000000AB; read 0x10 returns the cycles since reset; read 0x20, or any read with rd=0, returns 0.
REQ-042 Counting with TCON=3, then assert reset for 1 cycle mid-count -> all registers and irqout read 0 immediately; TL stays 0 after release until TCON is rewritten.
